// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall and taken-branch flush control for the MIPS IF/ID -> ID/EX boundary.
// Loads are tracked for LOAD_LAT cycles in a shift-register scoreboard; slot 0 is the load currently in EX.
// Optional stall-cycle counter is built only when HAZARD_PERF_CNT_EN is defined; otherwise stall_cycles is 0.
module hazard_stall_ctrl #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_ex_mem_read,
    input  logic [REG_W-1:0]  id_ex_rt,
    input  logic [REG_W-1:0]  if_id_rs,
    input  logic [REG_W-1:0]  if_id_rt,
    input  logic              if_id_uses_rt,
    input  logic              branch_taken,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              stall_ctrl,
    output logic              ifid_flush,
    output logic [PERF_W-1:0] stall_cycles
);

    logic                            v0;
    logic [LOAD_LAT-1:0]             v_all;
    logic [LOAD_LAT-1:0][REG_W-1:0]  r_all;
    logic                            match;

    // A write to register 0 never creates a dependency, so it is not tracked.
    assign v0 = id_ex_mem_read && (id_ex_rt != '0);

    generate
        if (LOAD_LAT > 1) begin : g_sb
            logic [LOAD_LAT-2:0]            pend_v_q;
            logic [LOAD_LAT-2:0][REG_W-1:0] pend_r_q;
            assign v_all = {pend_v_q, v0};
            assign r_all = {pend_r_q, id_ex_rt};
            // Age every tracked load by one slot each cycle; the oldest falls off the end.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pend_v_q <= '0;
                    pend_r_q <= '0;
                end else begin
                    pend_v_q <= v_all[LOAD_LAT-2:0];
                    pend_r_q <= r_all[LOAD_LAT-2:0];
                end
            end
        end else begin : g_nosb
            assign v_all = v0;
            assign r_all = id_ex_rt;
        end
    endgenerate

    // A source operand that is still unforwardable from any tracked load forces a stall.
    always_comb begin
        match = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            match = match | (v_all[k] &&
                    ((r_all[k] == if_id_rs && if_id_rs != '0) ||
                     (if_id_uses_rt && r_all[k] == if_id_rt && if_id_rt != '0)));
        end
    end

    // Reset holds the front end; a taken branch overrides a stall because the ID instruction is wrong-path.
    always_comb begin
        pc_en      = !reset_n ? 1'b0 : branch_taken ? 1'b1 : !match;
        ifid_en    = pc_en;
        stall_ctrl = !reset_n || branch_taken || match;
        ifid_flush = reset_n && branch_taken;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] stall_cycles_d;

    assign stall_cycles_d = (match && !branch_taken && !(&stall_cycles_q)) ? stall_cycles_q + 1'b1
                                                                           : stall_cycles_q;

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cycles_q <= '0;
        else          stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
